conv33_bias_loader: RTL and testbench
=====================================

Name: conv33_bias_loader

Overview:
Sequencer that feeds per-output-channel biases into the conv33 bias input buffer. For each output channel it fetches one bias word from a synchronous bias memory, pushes it with a load_en/load_data pulse, and waits for the buffer's bias_load acknowledge. It then issues a read_en pulse so the buffer presents the bias to the accumulator, and holds until the conv engine reports the channel finished. It sits between the bias ROM/BRAM and the bias input buffer and is driven by the conv33 top-level control.

Parameters:
BIAS_WIDTH, 32, width of one bias word
NUM_CH, 16, number of output channels (biases) per run, >=1
ADDR_WIDTH, 4, bias memory address width, >= clog2(NUM_CH), minimum 1

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle run request; sampled only in IDLE
mem_rd_en  output  1  bias memory read strobe
mem_addr  output  ADDR_WIDTH  bias memory address = current channel
mem_rd_data  input  BIAS_WIDTH  memory data, valid exactly 1 cycle after mem_rd_en
load_en  output  1  one-cycle load pulse to the bias buffer
load_data  output  BIAS_WIDTH  bias word; valid while load_en=1
bias_load  input  1  buffer load-complete pulse
read_en  output  1  one-cycle read pulse to the bias buffer
ch_done  input  1  conv engine finished the current channel
ch_idx  output  ADDR_WIDTH  current channel index
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the last channel completes

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, ch_idx=0
  - mem_rd_en, load_en, read_en, busy, done = 0
  - mem_addr=0, load_data=0, captured bias register=0
  - Reset mid-run abandons the run with no done pulse.
- All outputs are registered; output pulses are exactly one cycle wide.
- mem_addr always equals ch_idx.
- States and transitions:
  - IDLE: start=1 -> FETCH with ch_idx=0; otherwise stay.
  - FETCH (1 cycle): mem_rd_en=1 -> WAIT_MEM.
  - WAIT_MEM (1 cycle): capture mem_rd_data into the bias register -> LOAD.
  - LOAD (1 cycle): load_en=1, load_data=captured value -> WAIT_ACK.
  - WAIT_ACK: wait for bias_load=1, then -> ISSUE. No timeout.
  - ISSUE (1 cycle): read_en=1 -> WAIT_CH.
  - WAIT_CH: on ch_done=1, if ch_idx==NUM_CH-1 -> DONE, else ch_idx+1 and -> FETCH.
  - DONE (1 cycle): done=1, ch_idx cleared to 0 -> IDLE.
- load_data holds its value after LOAD until the next capture.
- Latency with a same-cycle-ack buffer (start sampled at edge 0):
  - mem_rd_en high in cycle 1, capture in cycle 2, load_en in cycle 3.
  - bias_load arrives in cycle 4; read_en in cycle 5.
  - WAIT_CH from cycle 6.
  - Per channel: 6 cycles plus ch_done wait.
- Boundary conditions:
  - start while busy: ignored.
  - bias_load outside WAIT_ACK: ignored; it is not remembered.
  - ch_done outside WAIT_CH: ignored; ch_done in the first WAIT_CH cycle is accepted.
  - ch_done held high continuously: advances one channel per WAIT_CH visit only.
  - NUM_CH=1: single pass, then DONE.
  - start in the DONE cycle: ignored; it is accepted in IDLE the following cycle.
  - ch_idx never exceeds NUM_CH-1; no wrap inside a run.
- No arithmetic is performed on bias data; it passes through bit-exact and unsigned-agnostic.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT_ACK -> all outputs 0 immediately (asynchronous), state IDLE; after release, start yields mem_rd_en with mem_addr=0.
- Single channel, NUM_CH=4, memory word k = 32'h1000_0000+k; start, buffer acks 1 cycle after load_en -> load_en in cycle 3 with load_data=32'h1000_0000; read_en in cycle 5.
- Full run NUM_CH=4, ch_done 3 cycles after each read_en -> four load_en pulses with data ...0000, ...0001, ...0002, ...0003 in order; one done pulse after the 4th ch_done; busy falls with done.
- Delayed ack: hold bias_load low 10 cycles -> load_en not repeated, read_en not issued until 1 cycle after bias_load.
- Spurious inputs: ch_done pulsed during WAIT_ACK and bias_load pulsed during WAIT_CH -> no state advance and no extra pulses.
- start pulsed during a run and in the DONE cycle -> ignored; a start one cycle after done begins a new run at ch_idx=0.

Source files
------------

// File: rtl/conv33_bias_loader.sv
// conv33_bias_loader: fetches one bias per output channel, loads it into the bias buffer, then waits for the channel to finish.
module conv33_bias_loader #(
  parameter int BIAS_WIDTH = 32,
  parameter int NUM_CH     = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [BIAS_WIDTH-1:0] mem_rd_data,
  output logic                  load_en,
  output logic [BIAS_WIDTH-1:0] load_data,
  input  logic                  bias_load,
  output logic                  read_en,
  input  logic                  ch_done,
  output logic [ADDR_WIDTH-1:0] ch_idx,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, LOAD, WAIT_ACK, ISSUE, WAIT_CH, DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST_CH = ADDR_WIDTH'(NUM_CH - 1);
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ch_idx_q, ch_idx_d;
  logic [BIAS_WIDTH-1:0]   bias_q, bias_d;
  logic                    mem_rd_en_q, mem_rd_en_d;
  logic                    load_en_q, load_en_d;
  logic                    read_en_q, read_en_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  always_comb begin
    state_d  = state_q;
    ch_idx_d = ch_idx_q;
    bias_d   = bias_q;
    case (state_q)
      IDLE: if (start) begin
        state_d  = FETCH;
        ch_idx_d = '0;
      end
      FETCH: state_d = WAIT_MEM;
      WAIT_MEM: begin
        bias_d  = mem_rd_data;
        state_d = LOAD;
      end
      LOAD:     state_d = WAIT_ACK;
      WAIT_ACK: state_d = bias_load ? ISSUE : WAIT_ACK;
      ISSUE:    state_d = WAIT_CH;
      WAIT_CH: if (ch_done) begin
        state_d  = (ch_idx_q == LAST_CH) ? DONE : FETCH;
        ch_idx_d = (ch_idx_q == LAST_CH) ? ch_idx_q : ch_idx_q + ADDR_WIDTH'(1);
      end
      DONE: begin
        state_d  = IDLE;
        ch_idx_d = '0;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so every pulse leaves a flop aligned with its state.
    mem_rd_en_d = state_d == FETCH;
    load_en_d   = state_d == LOAD;
    read_en_d   = state_d == ISSUE;
    busy_d      = state_d != IDLE;
    done_d      = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_idx_q    <= '0;
      bias_q      <= '0;
      mem_rd_en_q <= 1'b0;
      load_en_q   <= 1'b0;
      read_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_idx_q    <= ch_idx_d;
      bias_q      <= bias_d;
      mem_rd_en_q <= mem_rd_en_d;
      load_en_q   <= load_en_d;
      read_en_q   <= read_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = ch_idx_q;
  assign load_en   = load_en_q;
  assign load_data = bias_q;
  assign read_en   = read_en_q;
  assign ch_idx    = ch_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_conv33_bias_loader.sv
// tb_conv33_bias_loader: directed checks of the bias loader with NUM_CH=4 and a synchronous bias memory model.
module tb_conv33_bias_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_rd_en;
  logic [3:0]  mem_addr;
  logic [31:0] mem_rd_data = '0;
  logic        load_en;
  logic [31:0] load_data;
  logic        bias_load = 1'b0;
  logic        read_en;
  logic        ch_done = 1'b0;
  logic [3:0]  ch_idx;
  logic        busy;
  logic        done;
  int          pass_cnt = 0;
  int          total = 0;

  conv33_bias_loader #(.BIAS_WIDTH(32), .NUM_CH(4), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .load_en(load_en), .load_data(load_data), .bias_load(bias_load),
    .read_en(read_en), .ch_done(ch_done), .ch_idx(ch_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= 32'h1000_0000 + 32'(mem_addr);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Entry: the FETCH cycle of channel k. Exit: the cycle after ch_done is accepted.
  task automatic do_ch(input int k, input int ack_dly);
    chk("fetch rd_en", mem_rd_en, 1);
    chk("fetch addr", mem_addr, k);
    chk("fetch ch_idx", ch_idx, k);
    chk("fetch busy", busy, 1);
    tick;
    chk("wait_mem quiet", {mem_rd_en, load_en, read_en}, 0);
    tick;
    chk("load_en", load_en, 1);
    chk("load_data", load_data, 32'h1000_0000 + k);
    tick;
    chk("ack wait quiet", {mem_rd_en, load_en, read_en}, 0);
    repeat (ack_dly) begin
      chk("no reload", {mem_rd_en, load_en, read_en, done}, 0);
      ch_done = 1'b1;
      start = 1'b1;
      tick;
    end
    ch_done = 1'b0;
    start = 1'b0;
    bias_load = 1'b1;
    tick;
    bias_load = 1'b0;
    chk("read_en", read_en, 1);
    chk("issue load_en low", load_en, 0);
    tick;
    chk("wait_ch quiet", {mem_rd_en, load_en, read_en}, 0);
    chk("load_data held", load_data, 32'h1000_0000 + k);
    bias_load = 1'b1;
    tick;
    bias_load = 1'b0;
    chk("spurious ack ignored", {mem_rd_en, load_en, read_en, done}, 0);
    ch_done = 1'b1;
    tick;
    ch_done = 1'b0;
  endtask

  initial begin
    tick;
    chk("reset busy", busy, 0);
    chk("reset outs", {mem_rd_en, load_en, read_en, done}, 0);
    chk("reset ch_idx", ch_idx, 0);
    chk("reset load_data", load_data, 0);
    rst_n = 1'b1;
    tick;
    chk("idle busy", busy, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    do_ch(0, 0);
    do_ch(1, 10);
    do_ch(2, 0);
    do_ch(3, 2);
    chk("done pulse", done, 1);
    chk("done busy", busy, 1);
    chk("done no fetch", mem_rd_en, 0);
    start = 1'b1;
    tick;
    chk("done one cycle", done, 0);
    chk("idle after done", busy, 0);
    chk("start in done ignored", mem_rd_en, 0);
    chk("ch_idx cleared", ch_idx, 0);
    tick;
    start = 1'b0;
    chk("restart rd_en", mem_rd_en, 1);
    chk("restart addr", mem_addr, 0);
    ch_done = 1'b1;
    tick;
    tick;
    chk("held ch_done load", load_en, 1);
    chk("held ch_done ch_idx", ch_idx, 0);
    tick;
    bias_load = 1'b1;
    tick;
    bias_load = 1'b0;
    chk("held ch_done read_en", read_en, 1);
    tick;
    tick;
    chk("held ch_done next fetch", mem_rd_en, 1);
    chk("held ch_done one step", ch_idx, 1);
    tick;
    chk("held ch_done no skip", ch_idx, 1);
    ch_done = 1'b0;
    tick;
    tick;
    chk("pre-reset load_data", load_data, 32'h1000_0001);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outs", {mem_rd_en, load_en, read_en, busy, done}, 0);
    chk("async reset ch_idx", ch_idx, 0);
    chk("async reset load_data", load_data, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("post reset no done", {busy, done}, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("post reset rd_en", mem_rd_en, 1);
    chk("post reset addr", mem_addr, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
